// File: rtl/clock_divider_prog.sv
// Multi-channel run-time programmable clock divider: each channel emits a registered
// 50%-duty divided clock with single-cycle rise/fall strobes intended as clock enables.
module clock_divider_prog #(
  parameter int NCH         = 2,
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NCH-1:0]       i_en,
  input  logic [NCH-1:0]       i_load,
  input  logic [NCH*WIDTH-1:0] i_div,
  output logic [NCH-1:0]       o_clk,
  output logic [NCH-1:0]       o_rise,
  output logic [NCH-1:0]       o_fall,
  output logic [NCH-1:0]       o_run
);

  // STOPPING is not a separate encoding: it is CH_RUN with en low while the output is high.
  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    ch_state_e        state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic [WIDTH-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] div;
    logic             boundary;

    assign en       = i_en[n];
    assign load     = i_load[n];
    assign div      = i_div[n*WIDTH +: WIDTH];
    assign boundary = (cnt_q == act_q);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the combinational block below uses blocking assignments.
    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
        state_q <= CH_IDLE;
        cnt_q   <= '0;
        act_q   <= DIV_RST;
        shd_q   <= DIV_RST;
        pend_q  <= 1'b0;
        clk_q   <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        act_q   <= act_d;
        shd_q   <= shd_d;
        pend_q  <= pend_d;
        clk_q   <= clk_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a signal unassigned and infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      act_d   = act_q;
      shd_d   = shd_q;
      pend_d  = pend_q;
      clk_d   = clk_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;

      case (state_q)
        CH_IDLE: begin
          cnt_d = '0;
          clk_d = 1'b0;
          if (en) begin
            state_d = CH_RUN;
            // A load coinciding with the start bypasses the shadow register.
            if (load) begin
              act_d  = div;
              pend_d = 1'b0;
            end else if (pend_q) begin
              act_d  = shd_q;
              pend_d = 1'b0;
            end
          end else if (load) begin
            shd_d  = div;
            pend_d = 1'b1;
          end
        end

        CH_RUN: begin
          if (!en && !clk_q) begin
            // Low phase can be abandoned immediately without producing a runt.
            state_d = CH_IDLE;
            cnt_d   = '0;
            if (load) begin
              shd_d  = div;
              pend_d = 1'b1;
            end
          end else if (boundary) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            rise_d = ~clk_q;
            fall_d = clk_q;
            if (load) begin
              act_d  = div;
              pend_d = 1'b0;
            end else if (pend_q) begin
              act_d  = shd_q;
              pend_d = 1'b0;
            end
            // Falling boundary while disabled completes the stop.
            if (clk_q && !en) begin
              state_d = CH_IDLE;
            end
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
            if (load) begin
              shd_d  = div;
              pend_d = 1'b1;
            end
          end
        end

        default: state_d = CH_IDLE;
      endcase
    end

    assign o_clk[n]  = clk_q;
    assign o_rise[n] = rise_q;
    assign o_fall[n] = fall_q;
    assign o_run[n]  = (state_q == CH_RUN);
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog: directed table, corner sequences and
// randomized traffic compared cycle by cycle against a half-period reference model.
module tb_clock_divider_prog;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en;
  logic [1:0]  load;
  logic [15:0] div;
  logic [1:0]  d_clk, d_rise, d_fall, d_run;

  int n_vec = 0;
  int n_bad = 0;

  clock_divider_prog #(
    .NCH(2),
    .WIDTH(8),
    .DEFAULT_DIV(1)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (en),
    .i_load(load),
    .i_div (div),
    .o_clk (d_clk),
    .o_rise(d_rise),
    .o_fall(d_fall),
    .o_run (d_run)
  );

  always #5 clk = ~clk;

  // Reference model: each channel sits at a level for act+1 cycles, then flips.
  int m_act[2];
  int m_pend[2][$];
  int m_spent[2];
  bit m_run[2], m_lvl[2], m_rise[2], m_fall[2];

  function automatic void model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_act[ch]   = 1;
      m_pend[ch].delete();
      m_spent[ch] = 0;
      m_run[ch]   = 0;
      m_lvl[ch]   = 0;
      m_rise[ch]  = 0;
      m_fall[ch]  = 0;
    end
  endfunction

  function automatic void take(int ch, bit l, int d);
    if (l) begin
      m_act[ch] = d;
      m_pend[ch].delete();
    end else if (m_pend[ch].size() > 0) begin
      m_act[ch] = m_pend[ch].pop_front();
    end
  endfunction

  function automatic void park(int ch, int d);
    m_pend[ch].delete();
    m_pend[ch].push_back(d);
  endfunction

  function automatic void model_edge();
    for (int ch = 0; ch < 2; ch++) begin
      bit e = en[ch];
      bit l = load[ch];
      int d = int'(div[ch*8 +: 8]);
      m_rise[ch] = 0;
      m_fall[ch] = 0;
      if (!m_run[ch]) begin
        m_lvl[ch] = 0;
        if (e) begin
          m_run[ch]   = 1;
          m_spent[ch] = 1;
          take(ch, l, d);
        end else if (l) begin
          park(ch, d);
        end
      end else if (!e && !m_lvl[ch]) begin
        m_run[ch] = 0;
        if (l) park(ch, d);
      end else if (m_spent[ch] == m_act[ch] + 1) begin
        m_lvl[ch]   = !m_lvl[ch];
        m_rise[ch]  = m_lvl[ch];
        m_fall[ch]  = !m_lvl[ch];
        m_spent[ch] = 1;
        take(ch, l, d);
        if (!m_lvl[ch] && !e) m_run[ch] = 0;
      end else begin
        m_spent[ch]++;
        if (l) park(ch, d);
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic step();
    logic [7:0] exp_v;
    @(posedge clk);
    model_edge();
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      exp_v[6+ch] = m_lvl[ch];
      exp_v[4+ch] = m_rise[ch];
      exp_v[2+ch] = m_fall[ch];
      exp_v[ch]   = m_run[ch];
    end
    check("model_cmp", {d_clk, d_rise, d_fall, d_run}, {24'h0, exp_v});
  endtask

  task automatic sync_edge(input int ch, input string name);
    logic prev;
    bit   seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      prev = d_clk[ch];
      step();
      if (d_clk[ch] !== prev) seen = 1;
    end
    check(name, seen, 1);
  endtask

  task automatic half_len(input int ch, input int want, input string name);
    logic prev = d_clk[ch];
    int   n    = 0;
    bit   done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      step();
      n++;
      if (d_clk[ch] !== prev) done = 1;
    end
    check(name, n, want);
  endtask

  typedef struct {
    logic [1:0]  en;
    logic [1:0]  load;
    logic [15:0] div;
    logic [1:0]  exp_clk;
    logic [1:0]  exp_rise;
    logic [1:0]  exp_fall;
    logic [1:0]  exp_run;
  } vec_t;

  vec_t tbl[7];

  task automatic run_table(input string tag);
    for (int i = 0; i < 7; i++) begin
      en   = tbl[i].en;
      load = tbl[i].load;
      div  = tbl[i].div;
      step();
      check($sformatf("%s_row%0d", tag, i), {d_clk, d_rise, d_fall, d_run},
            {tbl[i].exp_clk, tbl[i].exp_rise, tbl[i].exp_fall, tbl[i].exp_run});
    end
    load = 2'b00;
  endtask

  initial begin
    logic prev;
    bit   got;
    bit   done;
    int   hi;

    // Default divide 1 from reset: ch0 enabled, first rise two edges after enable.
    tbl[0] = '{en:2'b01, load:2'b00, div:16'h0, exp_clk:2'b00, exp_rise:2'b00, exp_fall:2'b00, exp_run:2'b01};
    tbl[1] = '{en:2'b01, load:2'b00, div:16'h0, exp_clk:2'b00, exp_rise:2'b00, exp_fall:2'b00, exp_run:2'b01};
    tbl[2] = '{en:2'b01, load:2'b00, div:16'h0, exp_clk:2'b01, exp_rise:2'b01, exp_fall:2'b00, exp_run:2'b01};
    tbl[3] = '{en:2'b01, load:2'b00, div:16'h0, exp_clk:2'b01, exp_rise:2'b00, exp_fall:2'b00, exp_run:2'b01};
    tbl[4] = '{en:2'b01, load:2'b00, div:16'h0, exp_clk:2'b00, exp_rise:2'b00, exp_fall:2'b01, exp_run:2'b01};
    tbl[5] = '{en:2'b01, load:2'b00, div:16'h0, exp_clk:2'b00, exp_rise:2'b00, exp_fall:2'b00, exp_run:2'b01};
    tbl[6] = '{en:2'b01, load:2'b00, div:16'h0, exp_clk:2'b01, exp_rise:2'b01, exp_fall:2'b00, exp_run:2'b01};

    rst  = 1'b0;
    en   = 2'b00;
    load = 2'b00;
    div  = 16'h0;
    model_reset();
    #12;
    check("reset_state", {d_clk, d_rise, d_fall, d_run}, 0);
    rst = 1'b1;

    run_table("t1");

    // act=0 toggles every edge; then load 3 at a boundary gives 4-cycle halves.
    load = 2'b01; div = 16'h0000;
    step();
    load = 2'b00;
    sync_edge(0, "t2_sync");
    half_len(0, 1, "t2_half_div0_a");
    half_len(0, 1, "t2_half_div0_b");
    load = 2'b01; div = 16'h0003;
    step();
    load = 2'b00;
    half_len(0, 4, "t2_half_div3_a");
    half_len(0, 4, "t2_half_div3_b");

    // Drop enable one cycle after a rise with act=4: high phase keeps 5 cycles.
    load = 2'b01; div = 16'h0004;
    step();
    load = 2'b00;
    sync_edge(0, "t3_sync");
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = d_rise[0];
    end
    check("t3_rise_seen", got, 1);
    hi = 1;
    step();
    if (d_clk[0]) hi++;
    en[0] = 1'b0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (d_clk[0]) hi++;
      else done = 1;
    end
    check("t3_high_len", hi, 5);
    check("t3_fall_strobe", d_fall[0], 1);
    check("t3_run_off", d_run[0], 0);
    repeat (10) step();
    check("t3_stays_idle", {d_clk[0], d_run[0]}, 0);

    // Load coincident with a boundary takes effect directly; last of two loads wins.
    en = 2'b01; load = 2'b01; div = 16'h0002;
    step();
    load = 2'b00;
    sync_edge(0, "t4_sync");
    step();
    step();
    load = 2'b01; div = 16'h0005;
    prev = d_clk[0];
    step();
    load = 2'b00;
    check("t4_boundary_hit", d_clk[0], !prev);
    half_len(0, 6, "t4_direct_load");
    load = 2'b01; div = 16'h0006;
    step();
    div = 16'h0007;
    step();
    load = 2'b00;
    half_len(0, 4, "t4_old_half_kept");
    half_len(0, 8, "t4_last_wins");

    // ch0 at f/2 alongside ch1 at the largest divide value.
    en = 2'b11; load = 2'b11; div = {8'd255, 8'd0};
    step();
    load = 2'b00;
    sync_edge(1, "t5_sync_ch1");
    half_len(1, 256, "t5_ch1_half_max");
    load = 2'b10; div = {8'd3, 8'd0};
    step();
    load = 2'b00;
    half_len(0, 1, "t5_ch0_a");
    half_len(0, 1, "t5_ch0_b");
    sync_edge(1, "t5_sync_ch1b");
    half_len(1, 4, "t5_ch1_new");
    en = 2'b01;
    repeat (6) step();
    half_len(0, 1, "t5_ch0_c");

    // Asynchronous reset in the middle of a high phase.
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = d_clk[0];
    end
    check("t6_high_before_rst", got, 1);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check("t6_async_reset", {d_clk, d_rise, d_fall, d_run}, 0);
    en   = 2'b00;
    load = 2'b00;
    #2;
    rst = 1'b1;
    run_table("t6_restart");

    // Randomized traffic against the model.
    en = 2'b11;
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if ($urandom_range(0, 15) == 0) en[ch] = ~en[ch];
        load[ch] = ($urandom_range(0, 5) == 0);
        div[ch*8 +: 8] = ($urandom_range(0, 39) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
      end
      step();
    end
    load = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
